// File: rtl/fetch_pkg.sv
// Purpose: shared widths, defaults and types for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;

    localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam int              DEF_PC_STEP  = 4;

    // FETCH: request slot free or holding a request whose data will be kept.
    // DROP : an outstanding request's response must be thrown away.
    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry synchronous prefetch FIFO of {pc, inst}; flush overrides push/pop.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
// Ports: clock/reset_n; push+push_dat, pop, flush in; count, head_vld, head_dat out.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_vld,
    output fetch_entry_t     head_dat
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is reset too so the head outputs read zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count    = count_q;
    assign head_vld = (count_q != '0);
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Purpose: owns the PC, issues req/ack word fetches, buffers {pc, inst} for execute.
// Latency: ack in cycle N -> inst_valid in N+1 (empty FIFO); redirect clears output next cycle.
// Backpressure: inst_ready low fills the FIFO; no new request is issued once it would be full.
// Ports: clock/reset_n; imem_req/imem_addr/imem_ack/imem_rdata to memory;
//        inst_valid/inst/inst_pc/inst_ready to execute; redirect_valid/redirect_pc from branch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int              PC_STEP  = DEF_PC_STEP
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  STEP_C  = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0]  PC_MASK = ~(STEP_C - PC_W'(1));

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  imem_addr_q, imem_addr_d;
    logic             imem_req_q, imem_req_d;
    logic [PC_W-1:0]  redir_pc;
    logic             ack_fire, push, pop, head_vld;
    logic [CNT_W-1:0] count, count_next;
    fetch_entry_t     push_dat, head_dat;

    assign redir_pc = redirect_pc & PC_MASK;
    assign ack_fire = imem_req_q & imem_ack;
    // Only a FETCH-state response is kept; a redirect discards the same-cycle push/pop.
    assign push     = ack_fire & (state_q == FETCH) & ~redirect_valid;
    assign pop      = head_vld & inst_ready & ~redirect_valid;
    assign push_dat = '{pc: fetch_pc_q, inst: imem_rdata};

    always_comb begin
        count_next = count;
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // In FETCH imem_addr always tracks fetch_pc, so a pending request keeps its
    // address simply by fetch_pc not moving until the ack.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;
        imem_req_d  = imem_req_q;
        if (push) begin
            fetch_pc_d = fetch_pc_q + STEP_C;
        end
        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
        end
        case (state_q)
            FETCH: begin
                if (redirect_valid && imem_req_q && !imem_ack) begin
                    // Memory cannot cancel: hold req/addr and discard the reply later.
                    state_d = DROP;
                end else begin
                    imem_addr_d = fetch_pc_d;
                    imem_req_d  = (count_next < DEPTH_C);
                end
            end
            DROP: begin
                if (ack_fire) begin
                    state_d     = FETCH;
                    imem_addr_d = fetch_pc_d;
                    imem_req_d  = (count_next < DEPTH_C);
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= RESET_PC;
            imem_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
            imem_req_q  <= imem_req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = head_vld;
    assign inst       = head_dat.inst;
    assign inst_pc    = head_dat.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: directed self-checking bench for fetch_unit with a configurable memory model.
// Latency: n/a.
// Backpressure: inst_ready driven directly by the stimulus.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;

    // Memory model: 0 = manual ack, 1 = zero-wait (ack = req), 2 = three wait states.
    int                ack_mode = 0;
    logic              man_ack = 1'b0;
    logic [2:0]        ws_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign imem_ack   = (ack_mode == 1) ? imem_req :
                        (ack_mode == 2) ? (imem_req && ws_cnt == 3'd3) : man_ack;
    assign imem_rdata = imem_addr ^ 16'hA5A5;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) ws_cnt <= 3'd0;
        else          ws_cnt <= (imem_req && !imem_ack) ? ws_cnt + 3'd1 : 3'd0;
    end

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (16'h0000),
        .PC_STEP  (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        chk1 ({tag, "_vld"}, inst_valid, 1'b1);
        chk16({tag, "_pc"},  inst_pc, pc);
        chk16({tag, "_ins"}, inst, pc ^ 16'hA5A5);
    endtask

    initial begin
        logic [15:0] e;

        // Reset held for three cycles.
        step(3);
        chk1 ("rst_req",  imem_req, 1'b0);
        chk16("rst_addr", imem_addr, 16'h0000);
        chk1 ("rst_vld",  inst_valid, 1'b0);
        chk16("rst_inst", inst, 16'h0000);
        chk16("rst_pc",   inst_pc, 16'h0000);
        reset_n = 1'b1;
        step(1);
        chk1 ("first_req",  imem_req, 1'b1);
        chk16("first_addr", imem_addr, 16'h0000);

        // Zero-wait streaming: one instruction per cycle.
        ack_mode   = 1;
        inst_ready = 1'b1;
        step(1);
        for (int i = 0; i < 6; i++) begin
            e = 16'(i * 4);
            chk_head("stream", e);
            chk1("stream_req", imem_req, 1'b1);
            step(1);
        end

        // Wrap 0xFFFC -> 0x0000 (redirect lands on an ack cycle here).
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF8;
        step(1);
        redirect_valid = 1'b0;
        chk1 ("wrap_flush", inst_valid, 1'b0);
        chk16("wrap_addr",  imem_addr, 16'hFFF8);
        step(1);
        chk_head("wrap0", 16'hFFF8);
        step(1);
        chk_head("wrap1", 16'hFFFC);
        step(1);
        chk_head("wrap2", 16'h0000);

        // Backpressure: restart at 0 with ready low; exactly 4 entries accepted.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0000;
        inst_ready     = 1'b0;
        step(1);
        redirect_valid = 1'b0;
        chk1 ("bp_flush", inst_valid, 1'b0);
        chk16("bp_addr0", imem_addr, 16'h0000);
        step(4);
        chk1 ("bp_full_req", imem_req, 1'b0);
        chk16("bp_full_addr", imem_addr, 16'h0010);
        chk_head("bp_hold", 16'h0000);
        step(2);
        chk1 ("bp_still_req", imem_req, 1'b0);
        chk16("bp_still_pc", inst_pc, 16'h0000);
        inst_ready = 1'b1;
        step(1);
        chk_head("bp_drain4", 16'h0004);
        chk1 ("bp_resume_req", imem_req, 1'b1);
        chk16("bp_resume_addr", imem_addr, 16'h0010);
        step(1);
        chk_head("bp_drain8", 16'h0008);
        step(1);
        chk_head("bp_drain12", 16'h000C);
        step(1);
        chk_head("bp_drain16", 16'h0010);

        // Redirect while a 3-wait-state request to 0x0008 is pending.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0000;
        step(1);
        redirect_valid = 1'b0;
        ack_mode       = 2;
        step(3);
        chk1 ("ws_wait_vld", inst_valid, 1'b0);
        chk16("ws_wait_addr", imem_addr, 16'h0000);
        step(1);
        chk_head("ws_pc0", 16'h0000);
        step(5);
        chk16("ws_addr8", imem_addr, 16'h0008);
        chk1 ("ws_addr8_vld", inst_valid, 1'b0);
        // Low bits of redirect_pc are ignored: 0x0043 means 0x0040.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0043;
        step(1);
        redirect_valid = 1'b0;
        chk16("drop_hold_addr", imem_addr, 16'h0008);
        chk1 ("drop_hold_req",  imem_req, 1'b1);
        chk1 ("drop_vld",       inst_valid, 1'b0);
        step(1);
        chk16("drop_ack_addr", imem_addr, 16'h0008);
        step(1);
        chk16("drop_next_addr", imem_addr, 16'h0040);
        chk1 ("drop_next_req",  imem_req, 1'b1);
        chk1 ("drop_discard",   inst_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk1("drop_no_data", inst_valid, 1'b0);
        end
        step(1);
        chk_head("redir_40", 16'h0040);

        // Redirect on the same cycle as an ack (manual memory).
        ack_mode = 0;
        man_ack  = 1'b0;
        step(1);
        chk1("ack_redir_pre", inst_valid, 1'b0);
        man_ack        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step(1);
        man_ack        = 1'b0;
        redirect_valid = 1'b0;
        chk1 ("ack_redir_vld",  inst_valid, 1'b0);
        chk16("ack_redir_addr", imem_addr, 16'h0100);
        chk1 ("ack_redir_req",  imem_req, 1'b1);
        step(1);
        chk16("ack_redir_hold", imem_addr, 16'h0100);
        man_ack = 1'b1;
        step(1);
        chk_head("ack_redir_data", 16'h0100);
        chk16("fill_addr1", imem_addr, 16'h0104);
        inst_ready = 1'b0;
        step(1);
        step(1);
        man_ack = 1'b0;
        chk_head("fill_head", 16'h0100);
        chk1 ("fill_req",  imem_req, 1'b1);
        chk16("fill_addr", imem_addr, 16'h010C);

        // Asynchronous reset with 3 entries buffered and a request outstanding.
        #1;
        reset_n = 1'b0;
        #1;
        chk1 ("arst_req",  imem_req, 1'b0);
        chk1 ("arst_vld",  inst_valid, 1'b0);
        chk16("arst_addr", imem_addr, 16'h0000);
        chk16("arst_inst", inst, 16'h0000);
        chk16("arst_pc",   inst_pc, 16'h0000);
        step(1);
        reset_n = 1'b1;
        step(1);
        chk1 ("rerun_req",  imem_req, 1'b1);
        chk16("rerun_addr", imem_addr, 16'h0000);
        chk1 ("rerun_vld",  inst_valid, 1'b0);
        ack_mode   = 1;
        inst_ready = 1'b1;
        step(1);
        chk_head("rerun0", 16'h0000);
        step(1);
        chk_head("rerun1", 16'h0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
